// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ex_stage_pkg
// Purpose : Shared constants and types for the execute stage: ALU op codes,
//           forwarding selects and the multiply sequencing states.
// Revision: 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

  // ALU operation codes as delivered by the decode register
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Forwarding selects; 2'b11 falls back to the register-file value
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Multiply sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } ex_state_t;

endpackage : ex_stage_pkg
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : ex_stage_if
// Purpose : Bundle of decode-side inputs, forwarding sources and the
//           execute-to-memory register outputs of the execute stage.
// Revision: 1.0 - initial release
// ============================================================================
interface ex_stage_if #(
  parameter int W = 32
);
  // Pipeline control
  logic         enE;
  logic         flushE;
  // Decode register outputs
  logic         RegwriteD;
  logic         MemtoregD;
  logic         MemwriteD;
  logic [2:0]   ALUcontrolD;
  logic         ALUsrcD;
  logic         RegdstD;
  logic [4:0]   rtD;
  logic [4:0]   rdD;
  logic [15:0]  immediateD;
  logic [W-1:0] rdata1D;
  logic [W-1:0] rdata2D;
  // Forwarding
  logic [1:0]   fwdAE;
  logic [1:0]   fwdBE;
  logic [W-1:0] ALUoutM_fwd;
  logic [W-1:0] resultW;
  // Execute register outputs
  logic         RegwriteE;
  logic         MemtoregE;
  logic         MemwriteE;
  logic [W-1:0] ALUoutE;
  logic [W-1:0] writedataE;
  logic [4:0]   writeregE;
  logic         busyE;

  // Upstream / environment side
  modport master (
    output enE, flushE, RegwriteD, MemtoregD, MemwriteD, ALUcontrolD,
           ALUsrcD, RegdstD, rtD, rdD, immediateD, rdata1D, rdata2D,
           fwdAE, fwdBE, ALUoutM_fwd, resultW,
    input  RegwriteE, MemtoregE, MemwriteE, ALUoutE, writedataE,
           writeregE, busyE
  );

  // Execute stage side
  modport slave (
    input  enE, flushE, RegwriteD, MemtoregD, MemwriteD, ALUcontrolD,
           ALUsrcD, RegdstD, rtD, rdD, immediateD, rdata1D, rdata2D,
           fwdAE, fwdBE, ALUoutM_fwd, resultW,
    output RegwriteE, MemtoregE, MemwriteE, ALUoutE, writedataE,
           writeregE, busyE
  );

endinterface : ex_stage_if
`default_nettype wire

// File: rtl/ex_stage_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : seq_multiplier
// Purpose : Iterative shift-add multiplier, one partial product per cycle.
//           The low W bits of the product accumulate in acc and remain stable
//           once the sequence finishes until the next start.
// Revision: 1.0 - initial release
// ============================================================================
module seq_multiplier #(
  parameter int W          = 32,
  parameter int MUL_CYCLES = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         start,
  input  wire logic         flush,
  input  wire logic [W-1:0] multiplicand_in,
  input  wire logic [W-1:0] multiplier_in,
  output logic      [W-1:0] acc,
  output logic              done
);

  // Counter holds 0..MUL_CYCLES-1
  localparam int CW = $clog2(MUL_CYCLES);

  logic [CW-1:0] count;
  logic          running;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;

  // done marks the final iteration; acc is complete after this cycle's edge
  assign done = running && (count == CW'(MUL_CYCLES - 1));

  // Shift-add iteration; bits shifted past W are irrelevant to the low product
  always_ff @(posedge clk) begin
    if (rst) begin
      running      <= 1'b0;
      count        <= '0;
      acc          <= '0;
      multiplicand <= '0;
      multiplier   <= '0;
    end else if (flush) begin
      running <= 1'b0;
      count   <= '0;
    end else if (start) begin
      running      <= 1'b1;
      count        <= '0;
      acc          <= '0;
      multiplicand <= multiplicand_in;
      multiplier   <= multiplier_in;
    end else if (running) begin
      if (multiplier[0]) begin
        acc <= acc + multiplicand;
      end
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
      if (done) begin
        running <= 1'b0;
        count   <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule : seq_multiplier
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : ex_stage
// Purpose : MIPS execute stage. Forwarding muxes, ALU, execute-to-memory
//           register, and an iterative multiply that stalls the front end
//           through busyE while it runs.
// Revision: 1.0 - initial release
// ============================================================================
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int W          = 32,
  parameter int MUL_CYCLES = 32   // must equal W
) (
  input  wire logic  clk,
  input  wire logic  rst,
  ex_stage_if.slave  bus
);

  ex_state_t    state;
  ex_state_t    next_state;
  logic         busy;

  logic [W-1:0] src_a;
  logic [W-1:0] fwd_b;
  logic [W-1:0] src_b;
  logic [W-1:0] imm_ext;
  logic [W-1:0] alu_result;
  logic [4:0]   write_reg;
  logic         is_mul;
  logic         mul_start;
  logic         mul_done;
  logic [W-1:0] mul_acc;

  // Control captured when a multiply is issued; upstream is not re-sampled
  logic         lat_regwrite;
  logic         lat_memtoreg;
  logic         lat_memwrite;
  logic [4:0]   lat_writereg;
  logic [W-1:0] lat_fwd_b;

  assign imm_ext   = {{(W-16){bus.immediateD[15]}}, bus.immediateD};
  assign src_b     = bus.ALUsrcD ? imm_ext : fwd_b;
  assign write_reg = bus.RegdstD ? bus.rdD : bus.rtD;
  assign is_mul    = (bus.ALUcontrolD == ALU_MUL);
  assign mul_start = (state == IDLE) && is_mul && bus.enE && !bus.flushE;
  assign bus.busyE = busy;

  // Forwarding muxes for both operands
  always_comb begin
    case (bus.fwdAE)
      FWD_MEM: src_a = bus.ALUoutM_fwd;
      FWD_WB:  src_a = bus.resultW;
      default: src_a = bus.rdata1D;
    endcase
    case (bus.fwdBE)
      FWD_MEM: fwd_b = bus.ALUoutM_fwd;
      FWD_WB:  fwd_b = bus.resultW;
      default: fwd_b = bus.rdata2D;
    endcase
  end

  // Single-cycle ALU; multiply and reserved codes yield 0 here
  always_comb begin
    case (bus.ALUcontrolD)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {{(W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  seq_multiplier #(
    .W          (W),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk             (clk),
    .rst             (rst),
    .start           (mul_start),
    .flush           (bus.flushE),
    .multiplicand_in (src_a),
    .multiplier_in   (src_b),
    .acc             (mul_acc),
    .done            (mul_done)
  );

  // Multiply sequencing state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and stall request; a flush always returns to IDLE
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        busy = is_mul && !bus.flushE;
        if (mul_start) next_state = MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (mul_done) next_state = DONE;
      end
      DONE: begin
        busy = 1'b1;
        if (bus.enE) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (bus.flushE) next_state = IDLE;
  end

  // Capture the multiply's control and store data at issue
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_regwrite <= 1'b0;
      lat_memtoreg <= 1'b0;
      lat_memwrite <= 1'b0;
      lat_writereg <= '0;
      lat_fwd_b    <= '0;
    end else if (mul_start) begin
      lat_regwrite <= bus.RegwriteD;
      lat_memtoreg <= bus.MemtoregD;
      lat_memwrite <= bus.MemwriteD;
      lat_writereg <= write_reg;
      lat_fwd_b    <= fwd_b;
    end
  end

  // Execute-to-memory register: reset, flush, multiply sequencing, hold, capture
  always_ff @(posedge clk) begin
    if (rst || bus.flushE || mul_start || (state == MUL)) begin
      bus.RegwriteE  <= 1'b0;
      bus.MemtoregE  <= 1'b0;
      bus.MemwriteE  <= 1'b0;
      bus.ALUoutE    <= '0;
      bus.writedataE <= '0;
      bus.writeregE  <= '0;
    end else if (state == DONE) begin
      if (bus.enE) begin
        bus.RegwriteE  <= lat_regwrite;
        bus.MemtoregE  <= lat_memtoreg;
        bus.MemwriteE  <= lat_memwrite;
        bus.ALUoutE    <= mul_acc;
        bus.writedataE <= lat_fwd_b;
        bus.writeregE  <= lat_writereg;
      end
    end else if (bus.enE) begin
      bus.RegwriteE  <= bus.RegwriteD;
      bus.MemtoregE  <= bus.MemtoregD;
      bus.MemwriteE  <= bus.MemwriteD;
      bus.ALUoutE    <= alu_result;
      bus.writedataE <= fwd_b;
      bus.writeregE  <= write_reg;
    end
  end

endmodule : ex_stage
`default_nettype wire
